rf_wport_arbiter: RTL and testbench

Arbitration and scoreboard controller for the register file's single write port. It shares that port between the in-order pipeline writeback (WB) and results returning from the long-latency multiply/divide unit (MDU). MDU results are queued in a small FIFO, and their destination registers are tracked in a scoreboard. The block asserts a decode-stage stall on RAW/WAW hazards against pending MDU results. It sits between the WB stage, the MDU and the register file.

---
 rtl/rf_wport_arbiter_pkg.sv | 22 ++
 rtl/rf_wport_arbiter_if.sv | 51 +++++
 rtl/rf_wb_fifo.sv | 50 +++++
 rtl/rf_wport_arbiter.sv | 88 ++++++++
 tb/tb_rf_wport_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Entry layout matches what the MDU returns: destination plus result data.
package rf_wport_arbiter_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] R0 = '0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } mdu_ent_t;

    // One-hot register mask; r0 maps to no bit so it is never tracked.
    function automatic logic [31:0] rd_bit(input logic [AW-1:0] rd);
        rd_bit = 32'd0;
        if (rd != R0)
            rd_bit[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle: WB request, MDU return, MDU issue, decode probe, RF write.
// master = core side, slave = arbiter.
interface rf_wport_arbiter_if;
    import rf_wport_arbiter_pkg::*;

    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_hold;

    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_rd;
    logic [DW-1:0] mdu_data;

    logic          issue_valid;
    logic [AW-1:0] issue_rd;

    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_stall;

    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    modport master (
        output wb_valid, wb_rd, wb_data,
        input  wb_hold,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready,
        output issue_valid, issue_rd,
        output id_valid, id_rs1, id_rs2, id_rd,
        input  id_stall,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        output wb_hold,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready,
        input  issue_valid, issue_rd,
        input  id_valid, id_rs1, id_rs2, id_rd,
        output id_stall,
        output rf_we, rf_wa, rf_wd
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
// Pointers carry one extra wrap bit to tell full from empty.
module rf_wb_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mdu_ent_t din,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output mdu_ent_t head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wp;
    logic [PW:0] rp;
    mdu_ent_t    mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign head    = mem[rp[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp[PW-1:0]] <= din;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB and queued MDU results, with an
// aging override for the FIFO head and a scoreboard-driven decode stall.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_wport_arbiter_if.slave bus
);

    localparam int GW = $clog2(MAX_WAIT + 1);

    logic          full;
    logic          empty;
    mdu_ent_t      head;
    mdu_ent_t      din;
    logic [GW-1:0] age;
    logic [31:0]   pending;
    logic [31:0]   clr;
    logic [31:0]   set;
    logic [31:0]   eff;
    logic          force_g;
    logic          sel_head;
    logic          sel_wb;
    logic [AW-1:0] w_rd;
    logic [DW-1:0] w_data;

    assign din.rd   = bus.mdu_rd;
    assign din.data = bus.mdu_data;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.mdu_valid),
        .din   (din),
        .pop   (sel_head),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign force_g = !empty && (age == GW'(MAX_WAIT));

    always_comb begin
        sel_head = 1'b0;
        sel_wb   = 1'b0;
        priority case (1'b1)
            force_g:      sel_head = 1'b1;
            bus.wb_valid: sel_wb   = 1'b1;
            !empty:       sel_head = 1'b1;
            default:      ;
        endcase
    end

    assign w_rd   = sel_head ? head.rd   : bus.wb_rd;
    assign w_data = sel_head ? head.data : bus.wb_data;

    assign bus.rf_we     = (sel_head || sel_wb) && (w_rd != R0);
    assign bus.rf_wa     = bus.rf_we ? w_rd : R0;
    assign bus.rf_wd     = bus.rf_we ? w_data : '0;
    assign bus.wb_hold   = force_g && bus.wb_valid;
    assign bus.mdu_ready = !full;

    // The retiring register is covered by the RF write bypass this cycle.
    assign clr = sel_head ? rd_bit(head.rd) : 32'd0;
    assign set = bus.issue_valid ? rd_bit(bus.issue_rd) : 32'd0;
    assign eff = pending & ~clr;

    assign bus.id_stall = bus.id_valid &&
                          (eff[bus.id_rs1] || eff[bus.id_rs2] || eff[bus.id_rd]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age     <= '0;
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
            if (empty || sel_head)
                age <= '0;
            else if (age != GW'(MAX_WAIT))
                age <= age + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: expected RF writes are queued as
// stimulus is driven and matched against every observed write.
module tb_rf_wport_arbiter;
    import rf_wport_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rf_wport_arbiter_if bus();

    rf_wport_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       errors = 0;
    int       checks = 0;
    mdu_ent_t exp_q[$];
    mdu_ent_t mon_e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        mdu_ent_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.mdu_valid   = 1'b0;
        bus.mdu_rd      = '0;
        bus.mdu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexp_wr", 32'(bus.rf_wa), 32'hffff_ffff);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.rf_wa), 32'(mon_e.rd));
                chk("wr_data", bus.rf_wd, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int t5_mrd [17] = '{12, 13, 14, 14, 14, 14, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int t5_rdy [17] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int t5_hld [17] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int t5_hrd [3]  = '{12, 13, 14};
    int t4_hld [7]  = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        int k;
        int h;
        idle_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.mdu_ready), 1);
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_hold", 32'(bus.wb_hold), 0);
        chk("rst_stall", 32'(bus.id_stall), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("idle_we", 32'(bus.rf_we), 0);
        chk("idle_wa", 32'(bus.rf_wa), 0);
        chk("idle_wd", bus.rf_wd, 0);
        chk("idle_hold", 32'(bus.wb_hold), 0);
        chk("idle_stall", 32'(bus.id_stall), 0);
        chk("idle_ready", 32'(bus.mdu_ready), 1);
        step();

        // WB write lands the same cycle
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 32'h11;
        expect_wr(5'd5, 32'h11);
        @(negedge clk);
        chk("t1_we", 32'(bus.rf_we), 1);
        chk("t1_hold", 32'(bus.wb_hold), 0);
        step();
        bus.wb_valid = 1'b0;

        // RAW hazard on pending r7
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.id_valid    = 1'b1;
        bus.id_rd       = 5'd7;
        bus.id_rs1      = 5'd2;
        bus.id_rs2      = 5'd3;
        @(negedge clk);
        chk("t2_issue_stall", 32'(bus.id_stall), 0);
        step();
        bus.issue_valid = 1'b0;
        bus.id_rd       = 5'd8;
        bus.id_rs1      = 5'd7;
        bus.id_rs2      = 5'd1;
        @(negedge clk);
        chk("t2_stall_a", 32'(bus.id_stall), 1);
        step();
        @(negedge clk);
        chk("t2_stall_b", 32'(bus.id_stall), 1);
        step();
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd7;
        bus.mdu_data  = 32'h2A;
        expect_wr(5'd7, 32'h2A);
        @(negedge clk);
        chk("t2_stall_c", 32'(bus.id_stall), 1);
        chk("t2_acc_we", 32'(bus.rf_we), 0);
        step();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        chk("t2_grant_stall", 32'(bus.id_stall), 0);
        chk("t2_grant_we", 32'(bus.rf_we), 1);
        step();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("t2_after_we", 32'(bus.rf_we), 0);
        step();

        // MDU result one cycle after accept
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd9;
        bus.mdu_data  = 32'h33;
        expect_wr(5'd9, 32'h33);
        @(negedge clk);
        chk("t3_nobypass", 32'(bus.rf_we), 0);
        step();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        chk("t3_we", 32'(bus.rf_we), 1);
        step();

        // Aging forces the head under continuous WB
        k = 0;
        for (int c = 0; c < 7; c++) begin
            bus.wb_valid  = 1'b1;
            bus.wb_rd     = 5'd11;
            bus.wb_data   = 32'h100 + k;
            bus.mdu_valid = (c == 0);
            bus.mdu_rd    = 5'd10;
            bus.mdu_data  = 32'h44;
            if (t4_hld[c] != 0)
                expect_wr(5'd10, 32'h44);
            else
                expect_wr(5'd11, 32'h100 + k);
            @(negedge clk);
            chk($sformatf("t4_hold_c%0d", c), 32'(bus.wb_hold), 32'(t4_hld[c]));
            if (t4_hld[c] == 0)
                k++;
            step();
        end
        bus.wb_valid  = 1'b0;
        bus.mdu_valid = 1'b0;

        // Backpressure while full, order preserved
        k = 0;
        h = 0;
        for (int c = 0; c < 17; c++) begin
            bus.wb_valid  = 1'b1;
            bus.wb_rd     = 5'd20;
            bus.wb_data   = 32'h300 + k;
            bus.mdu_valid = (t5_mrd[c] != 0);
            bus.mdu_rd    = 5'(t5_mrd[c]);
            bus.mdu_data  = 32'h50 + t5_mrd[c];
            if (t5_hld[c] != 0) begin
                expect_wr(5'(t5_hrd[h]), 32'h50 + t5_hrd[h]);
                h++;
            end else begin
                expect_wr(5'd20, 32'h300 + k);
            end
            @(negedge clk);
            chk($sformatf("t5_ready_c%0d", c), 32'(bus.mdu_ready), 32'(t5_rdy[c]));
            chk($sformatf("t5_hold_c%0d", c), 32'(bus.wb_hold), 32'(t5_hld[c]));
            if (t5_hld[c] == 0)
                k++;
            step();
        end
        bus.wb_valid  = 1'b0;
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        chk("t5_drained_we", 32'(bus.rf_we), 0);
        step();

        // r0 result is popped without a write
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd0;
        bus.mdu_data  = 32'h99;
        @(negedge clk);
        chk("t6_acc_we", 32'(bus.rf_we), 0);
        step();
        bus.mdu_rd   = 5'd15;
        bus.mdu_data = 32'h77;
        expect_wr(5'd15, 32'h77);
        @(negedge clk);
        chk("t6_r0_we", 32'(bus.rf_we), 0);
        step();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        chk("t6_r15_we", 32'(bus.rf_we), 1);
        step();

        // Reset with two queued entries
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd21;
        bus.wb_data     = 32'h200;
        bus.mdu_valid   = 1'b1;
        bus.mdu_rd      = 5'd16;
        bus.mdu_data    = 32'h60;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd16;
        expect_wr(5'd21, 32'h200);
        @(negedge clk);
        chk("t7_ready0", 32'(bus.mdu_ready), 1);
        step();
        bus.wb_data   = 32'h201;
        bus.mdu_rd    = 5'd17;
        bus.mdu_data  = 32'h61;
        bus.issue_rd  = 5'd17;
        bus.id_valid  = 1'b1;
        bus.id_rs1    = 5'd16;
        bus.id_rs2    = 5'd0;
        bus.id_rd     = 5'd0;
        expect_wr(5'd21, 32'h201);
        @(negedge clk);
        chk("t7_pend", 32'(bus.id_stall), 1);
        step();
        chk("t7_full", 32'(bus.mdu_ready), 0);
        bus.wb_valid    = 1'b0;
        bus.mdu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        bus.id_rs2      = 5'd17;
        rst = 1'b1;
        #1;
        chk("t7_rst_ready", 32'(bus.mdu_ready), 1);
        chk("t7_rst_we", 32'(bus.rf_we), 0);
        chk("t7_rst_stall", 32'(bus.id_stall), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t7_post_we", 32'(bus.rf_we), 0);
        chk("t7_post_stall", 32'(bus.id_stall), 0);
        chk("t7_post_ready", 32'(bus.mdu_ready), 1);
        step();
        idle_in();

        chk("drain", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
